// File: rtl/renkon_ctrl_conv_stride.sv
// Sequencer for a strided convolution layer: walks input pixels, issues accumulator
// writes at valid window positions, then streams the finished feature map out.
module renkon_ctrl_conv_stride #(
    parameter int LWIDTH = 16,
    parameter int FACCUM = 10,
    parameter int PIPE   = 5
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              in_begin,
    input  logic              in_valid,
    input  logic              in_end,
    input  logic [1:0]        core_state,
    input  logic [LWIDTH-1:0] w_img_size,
    input  logic [LWIDTH-1:0] w_fil_size,
    input  logic [1:0]        w_stride_log,
    input  logic              first_input,
    input  logic              last_input,
    input  logic              out_stall,
    output logic              out_begin,
    output logic              out_valid,
    output logic              out_end,
    output logic              mem_feat_we,
    output logic              mem_feat_rst,
    output logic [FACCUM-1:0] mem_feat_addr,
    output logic [FACCUM-1:0] mem_feat_addr_d1,
    output logic              conv_oe,
    output logic [LWIDTH-1:0] w_fea_size,
    output logic              busy
);

    typedef enum logic {S_WAIT, S_ACTIVE} state_t;

    localparam logic [1:0] CS_INPUT  = 2'd2;
    localparam logic [1:0] CS_OUTPUT = 2'd3;

    state_t            state_q;
    logic [1:0]        rcs_q;
    logic [LWIDTH-1:0] img_q, fil_q, fea_q;
    logic [1:0]        slog_q;
    logic [LWIDTH-1:0] x_q, y_q, x_d, y_d;
    logic              wait_back_q, conv_valid_q, conv_end_q, first_q, last_q;
    logic              raw_begin_q, raw_valid_q, raw_end_q;
    logic [FACCUM-1:0] a0_q, a0_d;
    logic [PIPE-1:0]   we_pipe_q, rst_pipe_q;
    logic [FACCUM-1:0] addr_pipe_q [PIPE];
    logic [FACCUM-1:0] addr_d1_q;
    logic [PIPE:0]     begin_pipe_q, valid_pipe_q, end_pipe_q;

    logic              active, in_step, out_adv, conv_hit, img_last, fea_last;
    logic [LWIDTH-1:0] fil_m1, dx, dy, smask, limit, fea_new;
    logic              unused_in_end;

    always_comb begin
        unused_in_end = in_end;
        active   = (state_q == S_ACTIVE);
        in_step  = active && (rcs_q == CS_INPUT) && in_valid;
        out_adv  = active && (rcs_q == CS_OUTPUT) && !wait_back_q && !out_stall;
        fil_m1   = fil_q - LWIDTH'(1);
        dx       = x_q - fil_m1;
        dy       = y_q - fil_m1;
        smask    = (LWIDTH'(1) << slog_q) - LWIDTH'(1);
        conv_hit = in_step && (x_q >= fil_m1) && (y_q >= fil_m1)
                   && ((dx & smask) == '0) && ((dy & smask) == '0);
        img_last = (x_q == img_q - LWIDTH'(1)) && (y_q == img_q - LWIDTH'(1));
        fea_last = (x_q == fea_q - LWIDTH'(1)) && (y_q == fea_q - LWIDTH'(1));
        fea_new  = ((w_img_size - w_fil_size) >> w_stride_log) + LWIDTH'(1);
        limit    = (rcs_q == CS_OUTPUT) ? fea_q : img_q;

        // Raster walk shared by the input and output phases; frozen while waiting.
        x_d = x_q;
        y_d = y_q;
        if ((in_step || out_adv) && !wait_back_q) begin
            if (x_q == limit - LWIDTH'(1)) begin
                x_d = '0;
                y_d = (y_q == limit - LWIDTH'(1)) ? '0 : y_q + LWIDTH'(1);
            end else begin
                x_d = x_q + LWIDTH'(1);
            end
        end

        a0_d = a0_q;
        if (conv_end_q || wait_back_q) begin
            a0_d = '0;
        end else if (conv_valid_q || out_adv) begin
            a0_d = a0_q + FACCUM'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            state_q      <= S_WAIT;
            rcs_q        <= '0;
            img_q        <= '0;
            fil_q        <= '0;
            fea_q        <= '0;
            slog_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            wait_back_q  <= 1'b0;
            conv_valid_q <= 1'b0;
            conv_end_q   <= 1'b0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            raw_begin_q  <= 1'b0;
            raw_valid_q  <= 1'b0;
            raw_end_q    <= 1'b0;
            a0_q         <= '0;
            we_pipe_q    <= '0;
            rst_pipe_q   <= '0;
            addr_d1_q    <= '0;
            begin_pipe_q <= '0;
            valid_pipe_q <= '0;
            end_pipe_q   <= '0;
            for (int i = 0; i < PIPE; i++) addr_pipe_q[i] <= '0;
        end else begin
            rcs_q   <= core_state;
            first_q <= first_input;
            last_q  <= last_input;

            // out_end beats a coincident in_begin, so that begin is dropped.
            case (state_q)
                S_WAIT: begin
                    if (in_begin) begin
                        state_q <= S_ACTIVE;
                        img_q   <= w_img_size;
                        fil_q   <= w_fil_size;
                        slog_q  <= w_stride_log;
                        fea_q   <= fea_new;
                    end
                end
                S_ACTIVE: begin
                    if (out_end) state_q <= S_WAIT;
                end
                default: state_q <= S_WAIT;
            endcase

            x_q <= (state_q == S_WAIT) ? '0 : x_d;
            y_q <= (state_q == S_WAIT) ? '0 : y_d;

            if (out_adv && fea_last) begin
                wait_back_q <= 1'b1;
            end else if (in_begin) begin
                wait_back_q <= 1'b0;
            end

            conv_valid_q <= conv_hit;
            conv_end_q   <= in_step && img_last;
            raw_begin_q  <= in_step && last_q && img_last;
            raw_valid_q  <= out_adv;
            raw_end_q    <= out_adv && fea_last;
            a0_q         <= a0_d;

            we_pipe_q[0]    <= conv_valid_q;
            rst_pipe_q[0]   <= conv_valid_q && first_q;
            addr_pipe_q[0]  <= a0_q;
            begin_pipe_q[0] <= raw_begin_q;
            valid_pipe_q[0] <= raw_valid_q;
            end_pipe_q[0]   <= raw_end_q;
            for (int i = 1; i < PIPE; i++) begin
                we_pipe_q[i]   <= we_pipe_q[i-1];
                rst_pipe_q[i]  <= rst_pipe_q[i-1];
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
            for (int i = 1; i <= PIPE; i++) begin
                begin_pipe_q[i] <= begin_pipe_q[i-1];
                valid_pipe_q[i] <= valid_pipe_q[i-1];
                end_pipe_q[i]   <= end_pipe_q[i-1];
            end
            addr_d1_q <= addr_pipe_q[PIPE-1];
        end
    end

    assign busy             = (state_q == S_ACTIVE);
    assign w_fea_size       = fea_q;
    assign mem_feat_we      = we_pipe_q[PIPE-1];
    assign mem_feat_rst     = rst_pipe_q[PIPE-1];
    assign mem_feat_addr    = addr_pipe_q[PIPE-1];
    assign mem_feat_addr_d1 = addr_d1_q;
    assign conv_oe          = valid_pipe_q[PIPE-1];
    assign out_begin        = begin_pipe_q[PIPE];
    assign out_valid        = valid_pipe_q[PIPE];
    assign out_end          = end_pipe_q[PIPE];

endmodule

// File: tb/tb_renkon_ctrl_conv_stride.sv
// Scoreboard bench for renkon_ctrl_conv_stride; a PIPE=3 copy runs in lockstep
// with the default build to check the shorter write latency.
module tb_renkon_ctrl_conv_stride;

    localparam int LW = 16;
    localparam int FA = 10;
    localparam int P5 = 5;
    localparam int P3 = 3;

    logic          clk = 1'b0;
    logic          xrst, in_begin, in_valid, in_end, first_input, last_input, out_stall;
    logic [1:0]    core_state, w_stride_log;
    logic [LW-1:0] w_img_size, w_fil_size;

    logic          out_begin_a, out_valid_a, out_end_a, mem_feat_we_a, mem_feat_rst_a, conv_oe_a, busy_a;
    logic [FA-1:0] mem_feat_addr_a, mem_feat_addr_d1_a;
    logic [LW-1:0] w_fea_size_a;
    logic          out_begin_b, out_valid_b, out_end_b, mem_feat_we_b, mem_feat_rst_b, conv_oe_b, busy_b;
    logic [FA-1:0] mem_feat_addr_b, mem_feat_addr_d1_b;
    logic [LW-1:0] w_fea_size_b;

    renkon_ctrl_conv_stride #(.LWIDTH(LW), .FACCUM(FA), .PIPE(P5)) dut_a (
        .clk(clk), .xrst(xrst), .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
        .core_state(core_state), .w_img_size(w_img_size), .w_fil_size(w_fil_size),
        .w_stride_log(w_stride_log), .first_input(first_input), .last_input(last_input),
        .out_stall(out_stall), .out_begin(out_begin_a), .out_valid(out_valid_a),
        .out_end(out_end_a), .mem_feat_we(mem_feat_we_a), .mem_feat_rst(mem_feat_rst_a),
        .mem_feat_addr(mem_feat_addr_a), .mem_feat_addr_d1(mem_feat_addr_d1_a),
        .conv_oe(conv_oe_a), .w_fea_size(w_fea_size_a), .busy(busy_a)
    );

    renkon_ctrl_conv_stride #(.LWIDTH(LW), .FACCUM(FA), .PIPE(P3)) dut_b (
        .clk(clk), .xrst(xrst), .in_begin(in_begin), .in_valid(in_valid), .in_end(in_end),
        .core_state(core_state), .w_img_size(w_img_size), .w_fil_size(w_fil_size),
        .w_stride_log(w_stride_log), .first_input(first_input), .last_input(last_input),
        .out_stall(out_stall), .out_begin(out_begin_b), .out_valid(out_valid_b),
        .out_end(out_end_b), .mem_feat_we(mem_feat_we_b), .mem_feat_rst(mem_feat_rst_b),
        .mem_feat_addr(mem_feat_addr_b), .mem_feat_addr_d1(mem_feat_addr_d1_b),
        .conv_oe(conv_oe_b), .w_fea_size(w_fea_size_b), .busy(busy_b)
    );

    typedef struct {
        logic [FA-1:0] addr;
        logic          rst;
        int            at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb, en;
    int   ov_cycles[$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int model_addr = 0;
    int we_cnt_a = 0, rst_cnt_a = 0, we_cnt_b = 0;
    int ob_cnt = 0, ov_cnt = 0, oend_cnt = 0, oe_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: accumulator writes are popped off the scoreboards,
    // output-phase pulses are counted and read addresses must run 0,1,2,...
    always @(negedge clk) begin
        if (mem_feat_we_a === 1'b1) begin
            we_cnt_a++;
            if (mem_feat_rst_a === 1'b1) rst_cnt_a++;
            tests_run++;
            if (qa.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL we_unexpected_a: got we=1 addr=%0d at cycle %0d, expected no write", mem_feat_addr_a, cyc);
            end else begin
                ea = qa.pop_front();
                if (mem_feat_addr_a !== ea.addr || mem_feat_rst_a !== ea.rst || cyc != ea.at) begin
                    tests_failed++;
                    $display("[TB] FAIL write_a: got addr=%0d rst=%0b cycle=%0d, expected addr=%0d rst=%0b cycle=%0d",
                             mem_feat_addr_a, mem_feat_rst_a, cyc, ea.addr, ea.rst, ea.at);
                end
            end
        end
        if (mem_feat_we_b === 1'b1) begin
            we_cnt_b++;
            tests_run++;
            if (qb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL we_unexpected_b: got we=1 addr=%0d at cycle %0d, expected no write", mem_feat_addr_b, cyc);
            end else begin
                eb = qb.pop_front();
                if (mem_feat_addr_b !== eb.addr || mem_feat_rst_b !== eb.rst || cyc != eb.at) begin
                    tests_failed++;
                    $display("[TB] FAIL write_b: got addr=%0d rst=%0b cycle=%0d, expected addr=%0d rst=%0b cycle=%0d",
                             mem_feat_addr_b, mem_feat_rst_b, cyc, eb.addr, eb.rst, eb.at);
                end
            end
        end
        if (conv_oe_a === 1'b1) begin
            tests_run++;
            if (mem_feat_addr_d1_a !== FA'(oe_cnt)) begin
                tests_failed++;
                $display("[TB] FAIL read_addr: got %0d, expected %0d", mem_feat_addr_d1_a, oe_cnt);
            end
            oe_cnt++;
        end
        if (out_valid_a === 1'b1) begin
            ov_cnt++;
            ov_cycles.push_back(cyc);
        end
        if (out_begin_a === 1'b1) ob_cnt++;
        if (out_end_a === 1'b1) begin
            oend_cnt++;
            tests_run++;
            if (out_valid_a !== 1'b1 || ov_cnt != 16) begin
                tests_failed++;
                $display("[TB] FAIL out_end_align: got out_valid=%0b count=%0d, expected out_valid=1 count=16", out_valid_a, ov_cnt);
            end
        end
    end

    function automatic int fea_of(int img, int fil, int s);
        return ((img - fil) >> s) + 1;
    endfunction

    task automatic clear_board();
        qa.delete();
        qb.delete();
        ov_cycles.delete();
        model_addr = 0;
        we_cnt_a = 0; rst_cnt_a = 0; we_cnt_b = 0;
        ob_cnt = 0; ov_cnt = 0; oend_cnt = 0; oe_cnt = 0;
    endtask

    task automatic do_reset();
        xrst = 1'b1; in_begin = 1'b0; in_valid = 1'b0; in_end = 1'b0; out_stall = 1'b0;
        core_state = 2'd0; first_input = 1'b0; last_input = 1'b0;
        w_img_size = '0; w_fil_size = '0; w_stride_log = '0;
        repeat (3) @(negedge clk);
        xrst = 1'b0;
        clear_board();
    endtask

    task automatic start_layer(input int img, input int fil, input int s, input logic first, input logic last);
        w_img_size = LW'(img);
        w_fil_size = LW'(fil);
        w_stride_log = 2'(s);
        first_input = first;
        last_input = last;
        core_state = 2'd2;
        model_addr = 0;
        @(negedge clk);
        in_begin = 1'b1;
        @(negedge clk);
        in_begin = 1'b0;
    endtask

    // Stimulus side of the scoreboard: every pixel that lands on a stride
    // grid point of a full window queues one expected accumulator write.
    task automatic drive_pixels(input int img, input int fil, input int s, input int n);
        int x, y;
        for (int i = 0; i < n; i++) begin
            x = i % img;
            y = i / img;
            in_valid = 1'b1;
            if (x >= fil - 1 && y >= fil - 1 && ((x - fil + 1) % (1 << s)) == 0 && ((y - fil + 1) % (1 << s)) == 0) begin
                en.addr = FA'(model_addr);
                en.rst = first_input;
                en.at = cyc + P5 + 1;
                qa.push_back(en);
                en.at = cyc + P3 + 1;
                qb.push_back(en);
                model_addr++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (P5 + 4) @(negedge clk);
        tests_run++;
        if (qa.size() != 0 || qb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL missing_writes: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic wait_out_end(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_end_a === 1'b1) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({out_begin_a, out_valid_a, out_end_a, mem_feat_we_a, mem_feat_rst_a, conv_oe_a, busy_a, busy_b} !== 8'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000000",
                     {out_begin_a, out_valid_a, out_end_a, mem_feat_we_a, mem_feat_rst_a, conv_oe_a, busy_a, busy_b});
        end
        tests_run++;
        if (mem_feat_addr_a !== '0 || mem_feat_addr_d1_a !== '0 || w_fea_size_a !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got addr=%0d d1=%0d fea=%0d, expected 0 0 0", mem_feat_addr_a, mem_feat_addr_d1_a, w_fea_size_a);
        end
        start_layer(6, 3, 0, 1'b1, 1'b0);
        tests_run++;
        if (busy_a !== 1'b1 || w_fea_size_a !== LW'(fea_of(6, 3, 0))) begin
            tests_failed++;
            $display("[TB] FAIL begin_latch: got busy=%0b fea=%0d, expected busy=1 fea=%0d", busy_a, w_fea_size_a, fea_of(6, 3, 0));
        end
        xrst = 1'b1;
        @(negedge clk);
        xrst = 1'b0;
        tests_run++;
        if (busy_a !== 1'b0 || w_fea_size_a !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_clears: got busy=%0b fea=%0d, expected busy=0 fea=0", busy_a, w_fea_size_a);
        end
    endtask

    task automatic test_conv(input int img, input int fil, input int s, input logic first, input int n_we);
        do_reset();
        start_layer(img, fil, s, first, 1'b0);
        tests_run++;
        if (w_fea_size_a !== LW'(fea_of(img, fil, s))) begin
            tests_failed++;
            $display("[TB] FAIL fea_size: got %0d, expected %0d", w_fea_size_a, fea_of(img, fil, s));
        end
        drive_pixels(img, fil, s, img * img);
        drain();
        tests_run++;
        if (we_cnt_a != n_we || we_cnt_b != n_we || rst_cnt_a != (first ? n_we : 0)) begin
            tests_failed++;
            $display("[TB] FAIL write_counts: got we=%0d we3=%0d rst=%0d, expected we=%0d we3=%0d rst=%0d",
                     we_cnt_a, we_cnt_b, rst_cnt_a, n_we, n_we, first ? n_we : 0);
        end
        tests_run++;
        if (busy_a !== 1'b1 || ov_cnt != 0 || ob_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL no_output_yet: got busy=%0b valid=%0d begin=%0d, expected 1 0 0", busy_a, ov_cnt, ob_cnt);
        end
    endtask

    task automatic test_output(input bit with_stall);
        bit seen;
        int ones, fours;
        do_reset();
        start_layer(6, 3, 0, 1'b1, 1'b1);
        drive_pixels(6, 3, 0, 36);
        core_state = 2'd3;
        if (with_stall) begin
            repeat (6) @(negedge clk);
            out_stall = 1'b1;
            repeat (3) @(negedge clk);
            out_stall = 1'b0;
        end
        wait_out_end(seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL out_end_timeout: got no out_end in 300 cycles, expected one");
        end else begin
            if (!with_stall) in_begin = 1'b1;
            @(negedge clk);
            in_begin = 1'b0;
            tests_run++;
            if (busy_a !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL busy_fall: got %0b, expected 0", busy_a);
            end
            @(negedge clk);
            tests_run++;
            if (busy_a !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL begin_dropped: got busy=%0b, expected 0", busy_a);
            end
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (ob_cnt != 1 || ov_cnt != 16 || oend_cnt != 1 || oe_cnt != 16 || we_cnt_a != 16) begin
            tests_failed++;
            $display("[TB] FAIL output_counts: got begin=%0d valid=%0d end=%0d oe=%0d we=%0d, expected 1 16 1 16 16",
                     ob_cnt, ov_cnt, oend_cnt, oe_cnt, we_cnt_a);
        end
        ones = 0;
        fours = 0;
        for (int i = 1; i < ov_cycles.size(); i++) begin
            if (ov_cycles[i] - ov_cycles[i-1] == 1) ones++;
            if (ov_cycles[i] - ov_cycles[i-1] == 4) fours++;
        end
        tests_run++;
        if (ones != (with_stall ? 14 : 15) || fours != (with_stall ? 1 : 0)) begin
            tests_failed++;
            $display("[TB] FAIL valid_spacing: got %0d adjacent %0d gaps-of-3, expected %0d %0d",
                     ones, fours, with_stall ? 14 : 15, with_stall ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_layer(6, 3, 0, 1'b1, 1'b1);
        drive_pixels(6, 3, 0, 19);
        in_valid = 1'b1;
        xrst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        xrst = 1'b0;
        tests_run++;
        if ({out_begin_a, out_valid_a, out_end_a, mem_feat_we_a, mem_feat_rst_a, conv_oe_a, busy_a, mem_feat_we_b} !== 8'b0
            || mem_feat_addr_a !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got flags=%b addr=%0d, expected 00000000 addr=0",
                     {out_begin_a, out_valid_a, out_end_a, mem_feat_we_a, mem_feat_rst_a, conv_oe_a, busy_a, mem_feat_we_b}, mem_feat_addr_a);
        end
        clear_board();
        repeat (15) @(negedge clk);
        tests_run++;
        if (we_cnt_a != 0 || we_cnt_b != 0 || ov_cnt != 0 || ob_cnt != 0 || oend_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL ghost_pulses: got we=%0d we3=%0d valid=%0d begin=%0d end=%0d, expected all 0",
                     we_cnt_a, we_cnt_b, ov_cnt, ob_cnt, oend_cnt);
        end
        start_layer(6, 3, 0, 1'b1, 1'b0);
        drive_pixels(6, 3, 0, 36);
        drain();
        tests_run++;
        if (we_cnt_a != 16 || we_cnt_b != 16) begin
            tests_failed++;
            $display("[TB] FAIL restart_writes: got %0d/%0d, expected 16/16", we_cnt_a, we_cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_conv(6, 3, 0, 1'b1, 16);
        test_conv(7, 3, 1, 1'b0, 9);
        test_output(1'b0);
        test_output(1'b1);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
